// File: rtl/fc_irq_pkg.sv
// ============================================================================
// Module : fc_irq_pkg
// Brief  : Register map, priority type and STATUS layout shared by fc_irq_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_irq_pkg;

    localparam logic [5:0] REG_MASK        = 6'h00;
    localparam logic [5:0] REG_MASK_SET    = 6'h04;
    localparam logic [5:0] REG_MASK_CLR    = 6'h08;
    localparam logic [5:0] REG_PENDING     = 6'h0C;
    localparam logic [5:0] REG_PENDING_SET = 6'h10;
    localparam logic [5:0] REG_PENDING_CLR = 6'h14;
    localparam logic [5:0] REG_FIFO_DATA   = 6'h18;
    localparam logic [5:0] REG_STATUS      = 6'h1C;
    localparam logic [5:0] REG_PRIO0       = 6'h20;
    localparam logic [5:0] REG_PRIO1       = 6'h24;

    typedef logic [1:0] prio_t;

    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_CNT_W   = 8;
    localparam int STATUS_IRQ_BIT = 8;

endpackage

`default_nettype wire

// File: rtl/fc_irq_event_fifo.sv
// ============================================================================
// Module : fc_irq_event_fifo
// Brief  : Power-of-two event FIFO; push accepted on valid & fulln, pop on
//          non-empty only. Head data is presented combinationally.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_irq_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_valid_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   fulln_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign fulln_o = (count < CNT_W'(DEPTH));
    assign push    = push_valid_i && fulln_o;
    // A pop request against an empty FIFO is dropped, even with a same-cycle push.
    assign pop     = pop_i && (count != '0);
    assign head_o  = mem[rd_ptr];
    assign count_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fc_irq_ctrl.sv
// ============================================================================
// Module : fc_irq_ctrl
// Brief  : FC interrupt controller: edge-detected lines, mask/pending regs,
//          event FIFO on one line, encoded and one-hot request outputs.
//          Optional macro FC_IRQ_PRIO_EN adds 2-bit per-line priorities.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_irq_ctrl
    import fc_irq_pkg::*;
#(
    parameter int NB_IRQ         = 32,
    parameter int IRQ_ID_WIDTH   = $clog2(NB_IRQ),
    parameter int EVENT_ID_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_IRQ_LINE  = 26
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_IRQ-1:0]         events_i,
    input  logic                      event_fifo_valid_i,
    input  logic [EVENT_ID_WIDTH-1:0] event_fifo_data_i,
    output logic                      event_fifo_fulln_o,
    input  logic                      cfg_req_i,
    input  logic                      cfg_we_i,
    input  logic [5:0]                cfg_addr_i,
    input  logic [31:0]               cfg_wdata_i,
    output logic [31:0]               cfg_rdata_o,
    output logic                      irq_req_o,
    output logic [IRQ_ID_WIDTH-1:0]   irq_id_o,
    output logic [NB_IRQ-1:0]         irq_x_o,
    input  logic                      irq_ack_i,
    input  logic [IRQ_ID_WIDTH-1:0]   irq_ack_id_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NB_IRQ-1:0]         mask_q;
    logic [NB_IRQ-1:0]         pending_q;
    logic [NB_IRQ-1:0]         events_prev_q;
    logic [EVENT_ID_WIDTH-1:0] fifo_data_q;
    logic                      irq_req_q;
    logic [IRQ_ID_WIDTH-1:0]   irq_id_q;
    logic [31:0]               rdata_q;

    logic                      cfg_wr;
    logic                      cfg_rd;
    logic [NB_IRQ-1:0]         wdata_lines;
    logic [NB_IRQ-1:0]         pending_vis;
    logic [NB_IRQ-1:0]         ack_vec;
    logic [NB_IRQ-1:0]         set_vec;
    logic [NB_IRQ-1:0]         clr_vec;
    logic [NB_IRQ-1:0]         pending_next;
    logic [NB_IRQ-1:0]         mask_next;
    logic [NB_IRQ-1:0]         active;
    logic [IRQ_ID_WIDTH:0]     sel;
    logic [31:0]               rd_word;
    logic [31:0]               prio0_rd;
    logic [31:0]               prio1_rd;
    prio_t [NB_IRQ-1:0]        prio_q;

    logic [EVENT_ID_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_nonempty;
    logic                      fifo_pop_req;

    assign cfg_wr        = cfg_req_i && cfg_we_i;
    assign cfg_rd        = cfg_req_i && !cfg_we_i;
    assign wdata_lines   = cfg_wdata_i[NB_IRQ-1:0];
    assign fifo_nonempty = (fifo_count != '0);
    assign fifo_pop_req  = irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(FIFO_IRQ_LINE));

    fc_irq_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_ID_WIDTH)
    ) u_event_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (event_fifo_valid_i),
        .push_data_i  (event_fifo_data_i),
        .pop_i        (fifo_pop_req),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .fulln_o      (event_fifo_fulln_o)
    );

    // Highest priority wins; the strict '>' keeps the lowest index on ties.
    function automatic logic [IRQ_ID_WIDTH:0] select_irq(
        input logic [NB_IRQ-1:0]  act,
        input prio_t [NB_IRQ-1:0] prio
    );
        logic                    found;
        logic [IRQ_ID_WIDTH-1:0] id;
        prio_t                   best;
        found = 1'b0;
        id    = '0;
        best  = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            if (act[i] && (!found || (prio[i] > best))) begin
                found = 1'b1;
                id    = IRQ_ID_WIDTH'(i);
                best  = prio[i];
            end
        end
        return {found, id};
    endfunction

`ifdef FC_IRQ_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else if (cfg_wr) begin
            for (int i = 0; i < NB_IRQ; i++) begin
                if ((i < 16) && (cfg_addr_i == REG_PRIO0)) begin
                    prio_q[i] <= cfg_wdata_i[2*(i%16) +: 2];
                end else if ((i >= 16) && (cfg_addr_i == REG_PRIO1)) begin
                    prio_q[i] <= cfg_wdata_i[2*(i%16) +: 2];
                end
            end
        end
    end

    always_comb begin
        prio0_rd = '0;
        prio1_rd = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            if (i < 16) begin
                prio0_rd[2*(i%16) +: 2] = prio_q[i];
            end else begin
                prio1_rd[2*(i%16) +: 2] = prio_q[i];
            end
        end
    end
`else
    assign prio_q   = '0;
    assign prio0_rd = '0;
    assign prio1_rd = '0;
`endif

    // The FIFO line's pending bit mirrors FIFO occupancy and is never stored.
    always_comb begin
        pending_vis                = pending_q;
        pending_vis[FIFO_IRQ_LINE] = fifo_nonempty;
    end

    always_comb begin
        for (int i = 0; i < NB_IRQ; i++) begin
            ack_vec[i] = irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(i));
        end
    end

    always_comb begin
        set_vec = events_i & ~events_prev_q;
        clr_vec = ack_vec;
        if (cfg_wr && (cfg_addr_i == REG_PENDING_SET)) begin
            set_vec = set_vec | wdata_lines;
        end
        if (cfg_wr && (cfg_addr_i == REG_PENDING_CLR)) begin
            clr_vec = clr_vec | wdata_lines;
        end
        pending_next                = (pending_q & ~clr_vec) | set_vec;
        pending_next[FIFO_IRQ_LINE] = 1'b0;
    end

    always_comb begin
        mask_next = mask_q;
        if (cfg_wr) begin
            case (cfg_addr_i)
                REG_MASK:     mask_next = wdata_lines;
                REG_MASK_SET: mask_next = mask_q | wdata_lines;
                REG_MASK_CLR: mask_next = mask_q & ~wdata_lines;
                default:      mask_next = mask_q;
            endcase
        end
    end

    assign active = pending_vis & mask_q;
    assign sel    = select_irq(active, prio_q);

    always_comb begin
        rd_word = '0;
        case (cfg_addr_i)
            REG_MASK:      rd_word[NB_IRQ-1:0] = mask_q;
            REG_PENDING:   rd_word[NB_IRQ-1:0] = pending_vis;
            REG_FIFO_DATA: rd_word[EVENT_ID_WIDTH-1:0] = fifo_data_q;
            REG_STATUS: begin
                rd_word[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
                rd_word[STATUS_IRQ_BIT]                 = irq_req_q;
            end
            REG_PRIO0:     rd_word = prio0_rd;
            REG_PRIO1:     rd_word = prio1_rd;
            default:       rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q        <= '0;
            pending_q     <= '0;
            events_prev_q <= '0;
            fifo_data_q   <= '0;
            irq_req_q     <= 1'b0;
            irq_id_q      <= '0;
            rdata_q       <= '0;
        end else begin
            mask_q        <= mask_next;
            pending_q     <= pending_next;
            events_prev_q <= events_i;
            rdata_q       <= cfg_rd ? rd_word : 32'h0;
            if (fifo_pop_req && fifo_nonempty) begin
                fifo_data_q <= fifo_head;
            end
            // An ack blanks the request for one cycle so the core sees a clean re-evaluation.
            if (irq_ack_i) begin
                irq_req_q <= 1'b0;
                irq_id_q  <= '0;
            end else begin
                irq_req_q <= sel[IRQ_ID_WIDTH];
                irq_id_q  <= sel[IRQ_ID_WIDTH] ? sel[IRQ_ID_WIDTH-1:0] : '0;
            end
        end
    end

    assign irq_req_o   = irq_req_q;
    assign irq_id_o    = irq_id_q;
    assign cfg_rdata_o = rdata_q;

    always_comb begin
        for (int i = 0; i < NB_IRQ; i++) begin
            irq_x_o[i] = irq_req_q && (irq_id_q == IRQ_ID_WIDTH'(i));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_irq_ctrl.sv
// ============================================================================
// Module : tb_fc_irq_ctrl
// Brief  : Scoreboard bench for fc_irq_ctrl; honours FC_IRQ_PRIO_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_irq_ctrl;

    localparam int NB_IRQ = 32;
    localparam int IDW    = 5;
    localparam int EVW    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NB_IRQ-1:0] events = '0;
    logic            fifo_valid = 1'b0;
    logic [EVW-1:0]  fifo_data = '0;
    logic            fifo_fulln;
    logic            cfg_req = 1'b0;
    logic            cfg_we = 1'b0;
    logic [5:0]      cfg_addr = '0;
    logic [31:0]     cfg_wdata = '0;
    logic [31:0]     cfg_rdata;
    logic            irq_req;
    logic [IDW-1:0]  irq_id;
    logic [NB_IRQ-1:0] irq_x;
    logic            irq_ack = 1'b0;
    logic [IDW-1:0]  irq_ack_id = '0;

    logic            rd_valid = 1'b0;
    logic            obs_strobe = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        string          name;
        logic           req;
        logic [IDW-1:0] id;
        logic [31:0]    x;
        logic           fulln;
    } obs_exp_t;

    rd_exp_t  rd_q[$];
    obs_exp_t obs_q[$];

    fc_irq_ctrl #(
        .NB_IRQ         (NB_IRQ),
        .IRQ_ID_WIDTH   (IDW),
        .EVENT_ID_WIDTH (EVW),
        .FIFO_DEPTH     (4),
        .FIFO_IRQ_LINE  (26)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .events_i           (events),
        .event_fifo_valid_i (fifo_valid),
        .event_fifo_data_i  (fifo_data),
        .event_fifo_fulln_o (fifo_fulln),
        .cfg_req_i          (cfg_req),
        .cfg_we_i           (cfg_we),
        .cfg_addr_i         (cfg_addr),
        .cfg_wdata_i        (cfg_wdata),
        .cfg_rdata_o        (cfg_rdata),
        .irq_req_o          (irq_req),
        .irq_id_o           (irq_id),
        .irq_x_o            (irq_x),
        .irq_ack_i          (irq_ack),
        .irq_ack_id_i       (irq_ack_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_valid <= cfg_req && !cfg_we;

    // Monitor: compares whenever read data or an observation strobe is presented.
    always @(negedge clk) begin : monitor
        rd_exp_t  re;
        obs_exp_t oe;
        if (rd_valid) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: rdata=0x%08h with no expectation queued", cfg_rdata);
            end else begin
                re = rd_q.pop_front();
                if (cfg_rdata !== re.val) begin
                    n_bad++;
                    $display("FAIL %s: rdata=0x%08h expected 0x%08h", re.name, cfg_rdata, re.val);
                end
            end
        end
        if (obs_strobe) begin
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_obs: no expectation queued");
            end else begin
                oe = obs_q.pop_front();
                if (irq_req !== oe.req || irq_x !== oe.x || fifo_fulln !== oe.fulln ||
                    (oe.req && irq_id !== oe.id)) begin
                    n_bad++;
                    $display("FAIL %s: req=%0b id=%0d x=0x%08h fulln=%0b expected req=%0b id=%0d x=0x%08h fulln=%0b",
                             oe.name, irq_req, irq_id, irq_x, fifo_fulln, oe.req, oe.id, oe.x, oe.fulln);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        cfg_req  = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = addr;
        tick();
        cfg_req  = 1'b0;
    endtask

    task automatic check(input logic req, input logic [IDW-1:0] id, input logic fulln, input string name);
        obs_exp_t e;
        e.name  = name;
        e.req   = req;
        e.id    = id;
        e.x     = req ? (32'h1 << id) : 32'h0;
        e.fulln = fulln;
        obs_q.push_back(e);
        obs_strobe = 1'b1;
        @(negedge clk);
        #1;
        obs_strobe = 1'b0;
    endtask

    task automatic ack(input logic [IDW-1:0] id);
        irq_ack    = 1'b1;
        irq_ack_id = id;
        tick();
        irq_ack    = 1'b0;
    endtask

    task automatic pulse(input logic [NB_IRQ-1:0] lines);
        events = lines;
        tick();
        events = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) tick();
        rst = 1'b0;
        check(1'b0, 5'd0, 1'b1, "reset_outputs");
        rd(6'h0C, 32'h0, "reset_pending");
        rd(6'h1C, 32'h0, "reset_status");

        // Single line, mask bit 3.
        wr(6'h00, 32'h0000_0008);
        pulse(32'h1 << 3);
        check(1'b0, 5'd0, 1'b1, "edge3_t1_no_req");
        tick();
        check(1'b1, 5'd3, 1'b1, "edge3_t2_req");
        rd(6'h0C, 32'h0000_0008, "edge3_pending");
        ack(5'd3);
        check(1'b0, 5'd0, 1'b1, "ack3_blank");
        rd(6'h0C, 32'h0, "ack3_pending_clr");
        check(1'b0, 5'd0, 1'b1, "ack3_stays_low");

        // Simultaneous lines 5 and 2.
        wr(6'h00, 32'hFFFF_FFFF);
        pulse(32'h0000_0024);
        tick();
        check(1'b1, 5'd2, 1'b1, "dual_first_id2");
        ack(5'd2);
        check(1'b0, 5'd0, 1'b1, "dual_blank");
        tick();
        check(1'b1, 5'd5, 1'b1, "dual_second_id5");
        ack(5'd5);
        tick();
        check(1'b0, 5'd0, 1'b1, "dual_done");

        // Edge and ack on line 7 in the same cycle.
        pulse(32'h1 << 7);
        tick();
        check(1'b1, 5'd7, 1'b1, "line7_req");
        events     = 32'h1 << 7;
        irq_ack    = 1'b1;
        irq_ack_id = 5'd7;
        tick();
        events     = '0;
        irq_ack    = 1'b0;
        check(1'b0, 5'd0, 1'b1, "line7_blank");
        rd(6'h0C, 32'h0000_0080, "line7_set_wins");
        check(1'b1, 5'd7, 1'b1, "line7_reassert");
        ack(5'd7);
        tick();
        check(1'b0, 5'd0, 1'b1, "line7_done");

        // Event FIFO: fill, refused fifth push, ordered pops.
        fifo_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fifo_data = 8'h11 + 8'(k);
            tick();
        end
        fifo_data = 8'h15;
        tick();
        fifo_valid = 1'b0;
        check(1'b1, 5'd26, 1'b0, "fifo_full");
        rd(6'h1C, 32'h0000_0104, "fifo_status_full");
        for (int k = 0; k < 4; k++) begin
            ack(5'd26);
            rd(6'h18, 32'h11 + 32'(k), "fifo_pop_data");
            if (k < 3) check(1'b1, 5'd26, 1'b1, "fifo_reassert");
            else       check(1'b0, 5'd0, 1'b1, "fifo_empty_no_req");
        end
        rd(6'h0C, 32'h0, "fifo_pending26_clr");
        rd(6'h1C, 32'h0, "fifo_status_empty");

        // PENDING_SET with mask off, then MASK_SET.
        wr(6'h00, 32'h0);
        wr(6'h10, 32'h0000_0100);
        tick();
        check(1'b0, 5'd0, 1'b1, "pset_masked");
        rd(6'h0C, 32'h0000_0100, "pset_pending");
        wr(6'h04, 32'h0000_0100);
        check(1'b0, 5'd0, 1'b1, "mset_t1");
        tick();
        check(1'b1, 5'd8, 1'b1, "mset_t2_id8");
        rd(6'h00, 32'h0000_0100, "mask_readback");

        // Edge on line 4 together with PENDING_CLR of bits 4 and 8.
        events = 32'h1 << 4;
        wr(6'h14, 32'h0000_0110);
        events = '0;
        rd(6'h0C, 32'h0000_0010, "edge_beats_pclr");
        wr(6'h08, 32'h0000_0100);
        wr(6'h04, 32'h0000_0010);
        fifo_valid = 1'b1;
        fifo_data  = 8'h55;
        tick();
        fifo_valid = 1'b0;
        check(1'b1, 5'd4, 1'b1, "pre_reset_req");
        rd(6'h1C, 32'h0000_0101, "pre_reset_status");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check(1'b0, 5'd0, 1'b1, "midop_reset_outputs");
        rd(6'h1C, 32'h0, "midop_reset_status");
        rd(6'h0C, 32'h0, "midop_reset_pending");
        rd(6'h00, 32'h0, "midop_reset_mask");

        // Priority selection.
        wr(6'h00, 32'h0000_0003);
        wr(6'h20, 32'h0000_000D);
        wr(6'h10, 32'h0000_0003);
        tick();
`ifdef FC_IRQ_PRIO_EN
        check(1'b1, 5'd1, 1'b1, "prio_id1_wins");
        rd(6'h20, 32'h0000_000D, "prio0_readback");
`else
        check(1'b1, 5'd0, 1'b1, "fixed_id0_wins");
        rd(6'h20, 32'h0, "prio0_reads_zero");
`endif
        rd(6'h28, 32'h0, "unknown_addr_zero");
        rd(6'h04, 32'h0, "wo_reg_reads_zero");

        repeat (3) tick();
        if (rd_q.size() != 0 || obs_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expectations: rd=%0d obs=%0d expected 0 0", rd_q.size(), obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
